// File: rtl/idex_if.sv
// ID/EX stage bundle: decoded ID fields and WB bypass in, EX fields, stall requests and event counters out.
// The stage uses the slave side; the upstream pipeline (or a bench) drives the master side.
interface idex_if #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int CNT_WIDTH   = 16
);
   logic                   ext_stall;
   logic                   flush;
   logic                   id_valid;
   logic [XLEN-1:0]        id_pc;
   logic [RFIDX_WIDTH-1:0] id_rs1;
   logic [RFIDX_WIDTH-1:0] id_rs2;
   logic [RFIDX_WIDTH-1:0] id_rd;
   logic                   id_use_rs1;
   logic                   id_use_rs2;
   logic [XLEN-1:0]        id_rdata1;
   logic [XLEN-1:0]        id_rdata2;
   logic [XLEN-1:0]        id_imm;
   logic [7:0]             id_ctrl;
   logic [3:0]             id_aluctrl;
   logic                   wb_regwrite;
   logic [RFIDX_WIDTH-1:0] wb_rd;
   logic [XLEN-1:0]        wb_wdata;

   logic                   ex_valid;
   logic [XLEN-1:0]        ex_pc;
   logic [XLEN-1:0]        ex_rdata1;
   logic [XLEN-1:0]        ex_rdata2;
   logic [XLEN-1:0]        ex_imm;
   logic [RFIDX_WIDTH-1:0] ex_rs1;
   logic [RFIDX_WIDTH-1:0] ex_rs2;
   logic [RFIDX_WIDTH-1:0] ex_rd;
   logic [7:0]             ex_ctrl;
   logic [3:0]             ex_aluctrl;
   logic                   pc_stall;
   logic                   ifid_stall;
   logic [CNT_WIDTH-1:0]   stall_cnt;
   logic [CNT_WIDTH-1:0]   flush_cnt;

   modport slave (
      input  ext_stall, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
             id_rdata1, id_rdata2, id_imm, id_ctrl, id_aluctrl, wb_regwrite, wb_rd, wb_wdata,
      output ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
             ex_aluctrl, pc_stall, ifid_stall, stall_cnt, flush_cnt
   );

   modport master (
      output ext_stall, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
             id_rdata1, id_rdata2, id_imm, id_ctrl, id_aluctrl, wb_regwrite, wb_rd, wb_wdata,
      input  ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
             ex_aluctrl, pc_stall, ifid_stall, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register for the 5-stage RV32 core with load-use hazard detection,
// WB-to-ID bypass and saturating stall/flush event counters.
module idex_stage #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int CNT_WIDTH   = 16
) (
   input  logic    clk,
   input  logic    reset,
   idex_if.slave   bus
);
   localparam int CTRL_MEMREAD = 5;

   logic                   ex_valid;
   logic [XLEN-1:0]        ex_pc, ex_rdata1, ex_rdata2, ex_imm;
   logic [RFIDX_WIDTH-1:0] ex_rs1, ex_rs2, ex_rd;
   logic [7:0]             ex_ctrl;
   logic [3:0]             ex_aluctrl;
   logic [CNT_WIDTH-1:0]   stall_cnt, flush_cnt;

   logic                   ld_use;
   logic [XLEN-1:0]        byp_rdata1, byp_rdata2;

   always_comb begin
      ld_use = ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rd != '0) && bus.id_valid &&
               ((bus.id_use_rs1 && (bus.id_rs1 == ex_rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == ex_rd)));
   end

   // Register file reads before it writes, so a same-cycle WB write must be bypassed here.
   always_comb begin
      byp_rdata1 = bus.id_rdata1;
      byp_rdata2 = bus.id_rdata2;
      if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1))
         byp_rdata1 = bus.wb_wdata;
      if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2))
         byp_rdata2 = bus.wb_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid   <= 1'b0;
         ex_pc      <= '0;
         ex_rdata1  <= '0;
         ex_rdata2  <= '0;
         ex_imm     <= '0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_rd      <= '0;
         ex_ctrl    <= '0;
         ex_aluctrl <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else if (!bus.ext_stall) begin
         // Flush, load-use and an empty ID slot all load the same zeroed bubble.
         if (bus.flush || ld_use || !bus.id_valid) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rdata1  <= '0;
            ex_rdata2  <= '0;
            ex_imm     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= '0;
            ex_aluctrl <= '0;
         end else begin
            ex_valid   <= 1'b1;
            ex_pc      <= bus.id_pc;
            ex_rdata1  <= byp_rdata1;
            ex_rdata2  <= byp_rdata2;
            ex_imm     <= bus.id_imm;
            ex_rs1     <= bus.id_rs1;
            ex_rs2     <= bus.id_rs2;
            ex_rd      <= bus.id_rd;
            ex_ctrl    <= bus.id_ctrl;
            ex_aluctrl <= bus.id_aluctrl;
         end
         if (bus.flush) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
         end else if (ld_use) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   assign bus.pc_stall   = !reset && (bus.ext_stall || (ld_use && !bus.flush));
   assign bus.ifid_stall = bus.pc_stall;
   assign bus.ex_valid   = ex_valid;
   assign bus.ex_pc      = ex_pc;
   assign bus.ex_rdata1  = ex_rdata1;
   assign bus.ex_rdata2  = ex_rdata2;
   assign bus.ex_imm     = ex_imm;
   assign bus.ex_rs1     = ex_rs1;
   assign bus.ex_rs2     = ex_rs2;
   assign bus.ex_rd      = ex_rd;
   assign bus.ex_ctrl    = ex_ctrl;
   assign bus.ex_aluctrl = ex_aluctrl;
   assign bus.stall_cnt  = stall_cnt;
   assign bus.flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: a driver issues directed and random ID traffic and queues the
// expected EX state from a behavioural model; an independent monitor pops and compares.
module tb_idex_stage;
   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int CW   = 16;
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc, rdata1, rdata2, imm;
      logic [RW-1:0]   rs1, rs2, rd;
      logic [7:0]      ctrl;
      logic [3:0]      alu;
   } ex_t;

   typedef struct {
      logic        stall;
      ex_t         ex;
      int unsigned scnt;
      int unsigned fcnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   ex_t         m_ex;
   int unsigned m_scnt, m_fcnt;

   idex_if #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .CNT_WIDTH(CW)) bus ();
   idex_stage #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural reference: what EX must hold one cycle after the current ID/WB inputs.
   task automatic tick();
      exp_t e;
      ex_t  nxt;
      logic hazard;
      #1;
      hazard = m_ex.valid && m_ex.ctrl[5] && m_ex.rd != 0 && bus.id_valid &&
               ((bus.id_use_rs1 && bus.id_rs1 == m_ex.rd) || (bus.id_use_rs2 && bus.id_rs2 == m_ex.rd));
      e.stall = !reset && (bus.ext_stall || (hazard && !bus.flush));
      nxt = '0;
      if (reset) begin
         m_scnt = 0;
         m_fcnt = 0;
      end else if (bus.ext_stall) begin
         nxt = m_ex;
      end else if (bus.flush) begin
         if (m_fcnt < CNT_MAX) m_fcnt++;
      end else if (hazard) begin
         if (m_scnt < CNT_MAX) m_scnt++;
      end else if (bus.id_valid) begin
         nxt.valid  = 1'b1;
         nxt.pc     = bus.id_pc;
         nxt.imm    = bus.id_imm;
         nxt.rs1    = bus.id_rs1;
         nxt.rs2    = bus.id_rs2;
         nxt.rd     = bus.id_rd;
         nxt.ctrl   = bus.id_ctrl;
         nxt.alu    = bus.id_aluctrl;
         nxt.rdata1 = (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == bus.id_rs1) ? bus.wb_wdata : bus.id_rdata1;
         nxt.rdata2 = (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == bus.id_rs2) ? bus.wb_wdata : bus.id_rdata2;
      end
      m_ex   = nxt;
      e.ex   = nxt;
      e.scnt = m_scnt;
      e.fcnt = m_fcnt;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.ext_stall = 0; bus.flush = 0; bus.id_valid = 0; bus.id_pc = '0;
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
      bus.id_rdata1 = '0; bus.id_rdata2 = '0; bus.id_imm = '0; bus.id_ctrl = '0; bus.id_aluctrl = '0;
      bus.wb_regwrite = 0; bus.wb_rd = '0; bus.wb_wdata = '0;
   endtask

   task automatic set_id(input logic [XLEN-1:0] pc, input int rs1, input int rs2, input int rd,
                         input logic u1, input logic u2, input logic [XLEN-1:0] d1,
                         input logic [XLEN-1:0] d2, input logic [7:0] ctrl);
      bus.id_valid = 1; bus.id_pc = pc;
      bus.id_rs1 = RW'(rs1); bus.id_rs2 = RW'(rs2); bus.id_rd = RW'(rd);
      bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
      bus.id_rdata1 = d1; bus.id_rdata2 = d2; bus.id_imm = pc + 32'h4; bus.id_ctrl = ctrl;
      bus.id_aluctrl = pc[3:0];
   endtask

   localparam logic [7:0] C_LOAD = 8'b1110_1000;
   localparam logic [7:0] C_ALU  = 8'b1000_0000;
   localparam logic [7:0] C_ADDI = 8'b1000_1000;

   // Monitor: combinational stall outputs mid-cycle, registered state after the edge.
   initial begin
      exp_t e;
      ex_t  act;
      forever begin
         @(negedge clk);
         #2;
         if (sb_q.size() != 0) begin
            e = sb_q[0];
            n_checks++;
            if (bus.pc_stall !== e.stall || bus.ifid_stall !== e.stall) begin
               n_fail++;
               $display("FAIL stall t=%0t pc_stall=%b ifid_stall=%b expected=%b", $time, bus.pc_stall, bus.ifid_stall, e.stall);
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            act = {bus.ex_valid, bus.ex_pc, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm,
                   bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_ctrl, bus.ex_aluctrl};
            n_checks++;
            if (act !== e.ex) begin
               n_fail++;
               $display("FAIL ex_regs t=%0t got=%h expected=%h", $time, act, e.ex);
            end
            n_checks++;
            if (bus.stall_cnt !== CW'(e.scnt)) begin
               n_fail++;
               $display("FAIL stall_cnt t=%0t got=%0d expected=%0d", $time, bus.stall_cnt, e.scnt);
            end
            n_checks++;
            if (bus.flush_cnt !== CW'(e.fcnt)) begin
               n_fail++;
               $display("FAIL flush_cnt t=%0t got=%0d expected=%0d", $time, bus.flush_cnt, e.fcnt);
            end
         end
      end
   end

   initial begin
      m_ex = '0; m_scnt = 0; m_fcnt = 0;
      idle();
      reset = 1;
      @(negedge clk);
      tick();
      reset = 0;

      // Normal capture
      set_id(32'h100, 2, 3, 4, 1, 1, 32'h11, 32'h22, C_ALU); tick();
      // Load-use: lw x5 then add x6,x5,x1 held for the stall cycle
      set_id(32'h104, 1, 0, 5, 1, 0, 32'h40, 32'h0, C_LOAD); tick();
      set_id(32'h108, 5, 1, 6, 1, 1, 32'h7, 32'h9, C_ALU); tick(); tick();
      // No false hazard: load to x0, then reader of x0
      set_id(32'h10c, 1, 0, 0, 1, 0, 32'h1, 32'h0, C_LOAD); tick();
      set_id(32'h110, 0, 0, 7, 1, 1, 32'h0, 32'h0, C_ALU); tick();
      // No false hazard: addi whose rs2 field aliases the load rd
      set_id(32'h114, 1, 0, 5, 1, 0, 32'h1, 32'h0, C_LOAD); tick();
      set_id(32'h118, 1, 5, 8, 1, 0, 32'h3, 32'h5, C_ADDI); tick();
      // Flush beats load-use
      set_id(32'h11c, 1, 0, 5, 1, 0, 32'h1, 32'h0, C_LOAD); tick();
      set_id(32'h120, 5, 2, 9, 1, 1, 32'h1, 32'h2, C_ALU); bus.flush = 1; tick();
      bus.flush = 0;
      // ext_stall freeze with a flush in the middle cycle
      set_id(32'h124, 3, 4, 10, 1, 1, 32'hAA, 32'hBB, C_ALU); tick();
      bus.ext_stall = 1;
      for (int i = 0; i < 3; i++) begin
         set_id($urandom, 1, 2, 11, 1, 1, $urandom, $urandom, C_LOAD);
         bus.flush = (i == 1);
         tick();
      end
      bus.ext_stall = 0; bus.flush = 0;
      // WB bypass, then the same with wb_rd=0
      set_id(32'h128, 1, 7, 12, 1, 1, 32'h5, 32'h0, C_ALU);
      bus.wb_regwrite = 1; bus.wb_rd = 7; bus.wb_wdata = 32'hDEAD; tick();
      bus.id_rs2 = 0; bus.wb_rd = 0; tick();
      bus.wb_regwrite = 0;
      // Reset while a load-use hazard is pending
      set_id(32'h12c, 1, 0, 5, 1, 0, 32'h1, 32'h0, C_LOAD); tick();
      set_id(32'h130, 5, 5, 6, 1, 1, 32'h1, 32'h2, C_ALU); reset = 1; tick();
      reset = 0;

      // Randomised traffic over a small register window so hazards and bypasses are frequent
      for (int i = 0; i < 3000; i++) begin
         set_id($urandom, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom), 1'($urandom), $urandom, $urandom, 8'($urandom));
         bus.id_valid    = ($urandom_range(0, 7) != 0);
         bus.flush       = ($urandom_range(0, 9) == 0);
         bus.ext_stall   = ($urandom_range(0, 9) == 0);
         bus.wb_regwrite = 1'($urandom);
         bus.wb_rd       = RW'($urandom_range(0, 7));
         bus.wb_wdata    = $urandom;
         reset           = ($urandom_range(0, 199) == 0);
         tick();
      end
      idle();
      reset = 0;

      // Flush counter saturation
      bus.flush = 1;
      for (int i = 0; i < (1 << CW) + 2; i++) tick();
      bus.flush = 0;
      tick();

      @(posedge clk);
      #3;
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d pending expected=0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32 pipeline.
- Captures decoded operands and controls from ID and presents them to EX. The forwarding unit consumes its rs1/rs2/rdata outputs.
- Inserts bubbles on load-use hazards and on branch flush.
- Applies WB-to-ID bypass, because the register file reads before it writes.
- Keeps saturating stall and flush event counters.

Parameters:
XLEN, 32, datapath width
RFIDX_WIDTH, 5, register index width
CNT_WIDTH, 16, width of event counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ext_stall  in  1  global pipeline freeze (memory not ready)
flush  in  1  branch/jump taken in EX; kill the instruction in ID
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2, id_rd  in  RFIDX_WIDTH  register indices
id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
id_rdata1, id_rdata2  in  XLEN  register file read data
id_imm  in  XLEN  immediate
id_ctrl  in  8  {regwrite, memtoreg, memread, memwrite, alusrc, branch, jump, lui}
id_aluctrl  in  4  ALU op
wb_regwrite  in  1  WB write enable
wb_rd  in  RFIDX_WIDTH  WB destination
wb_wdata  in  XLEN  WB data
ex_valid  out  1  registered valid
ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  XLEN  registered fields
ex_rs1, ex_rs2, ex_rd  out  RFIDX_WIDTH  registered indices
ex_ctrl  out  8  registered controls (same bit order as id_ctrl)
ex_aluctrl  out  4  registered ALU op
pc_stall  out  1  hold PC (combinational)
ifid_stall  out  1  hold IF/ID register (combinational)
stall_cnt, flush_cnt  out  CNT_WIDTH  event counters

Behaviour:
- Reset (synchronous, takes effect on the clk edge while reset=1):
  - All registered outputs become 0: ex_valid=0, ex_ctrl=0, indices 0, data 0.
  - Both counters become 0.
- Load-use detection (combinational), ld_use is true when all of the following hold:
  - ex_valid and ex_ctrl.memread
  - ex_rd != 0
  - id_valid
  - (id_use_rs1 and id_rs1 == ex_rd) or (id_use_rs2 and id_rs2 == ex_rd)
- Stall outputs:
  - pc_stall = ifid_stall = ext_stall | (ld_use & ~flush).
  - Both are 0 during reset.
- WB bypass, applied before capture:
  - If wb_regwrite and wb_rd != 0 and wb_rd == id_rs1, the captured rdata1 is wb_wdata. Otherwise it is id_rdata1.
  - rdata2 follows the same rule using id_rs2.
- Register update per clk edge, priority highest first:
  1. reset: clear everything.
  2. ext_stall=1: hold all registers. Counters do not change. A flush asserted in the same cycle is ignored; the source must hold it until ext_stall drops.
  3. flush=1: load a bubble and increment flush_cnt. This takes priority over ld_use, and stall_cnt does not increment.
  4. ld_use=1: load a bubble and increment stall_cnt. ID contents are preserved upstream via ifid_stall.
  5. Otherwise: capture the ID fields (with bypass); ex_valid = id_valid.
- Bubble definition: ex_valid=0, ex_ctrl=0, ex_aluctrl=0, ex_rd=ex_rs1=ex_rs2=0, data fields 0. A bubble never causes a write and never matches forwarding.
- If id_valid=0 in the normal-capture case, the register is loaded as a bubble and ld_use is never raised.
- Latency: one cycle from ID to EX. A load-use hazard costs exactly one bubble, after which the load result is forwarded from MEM/WB.
- Counters saturate at all-ones and do not wrap.
- Reset during a stall or flush: reset wins, and the stall outputs deassert immediately.

Test Plan:
- Normal capture:
  - Stimulus: reset, then id_valid=1, id_pc=0x100, rs1=2, rs2=3, rd=4, rdata1=0x11, rdata2=0x22, regwrite=1.
  - Required: one clk later ex_pc=0x100, ex_rd=4, ex_rdata1=0x11, ex_valid=1; pc_stall=0.
- Load-use:
  - Stimulus: EX holds lw x5 (memread=1, rd=5); ID holds add x6,x5,x1 with use_rs1=1.
  - Required: pc_stall=ifid_stall=1 that cycle; next edge ex_valid=0, ex_ctrl=0, stall_cnt=1; following edge add is captured with rs1=5.
- No false hazard:
  - Case 1: load to x0 with ID reading x0 -> no stall.
  - Case 2: load rd=5 with ID instruction of use_rs2=0 and rs2=5 (e.g. addi) -> no stall.
- Flush priority:
  - Stimulus: flush=1 and ld_use=1 in the same cycle.
  - Required: pc_stall=0, bubble loaded, flush_cnt=1, stall_cnt=0.
- ext_stall freeze:
  - Stimulus: a captured instruction is in EX, then ext_stall=1 for 3 cycles with flush=1 in cycle 2.
  - Required: EX outputs unchanged for all 3 cycles; counters unchanged.
- WB bypass and saturation:
  - Bypass: wb_regwrite=1, wb_rd=7, wb_wdata=0xDEAD, id_rs2=7, id_rdata2=0x0 -> ex_rdata2=0xDEAD. Same with wb_rd=0 -> ex_rdata2=0.
  - Saturation: drive 2^CNT_WIDTH+2 flushes -> flush_cnt stays 0xFFFF.
